// File: rtl/bev_sched_pkg.sv
// rtl/bev_sched_pkg.sv - shared scheduler state encoding and default vend timing
package bev_sched_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DISP    = 3'd1,
    CHG_ON  = 3'd2,
    CHG_GAP = 3'd3,
    DONE    = 3'd4
  } sched_state_e;

  localparam int DEF_N_REQ     = 4;
  localparam int DEF_CHG_W     = 3;
  localparam int DEF_DISP_CYC  = 4;
  localparam int DEF_PULSE_CYC = 2;
  localparam int DEF_GAP_CYC   = 2;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/beverage_dispense_scheduler_rr_arbiter.sv
// rtl/beverage_dispense_scheduler_rr_arbiter.sv - combinational round-robin pick starting at rr_ptr
module rr_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] rr_ptr,
  output logic [N_REQ-1:0]         gnt,
  output logic [$clog2(N_REQ)-1:0] gnt_idx,
  output logic                     gnt_valid
);

  localparam int IDX_W = $clog2(N_REQ);

  logic [IDX_W-1:0] cand;

  // Scan from the farthest candidate back to rr_ptr so the nearest set bit wins.
  always_comb begin
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    cand      = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = IDX_W'((int'(rr_ptr) + k) % N_REQ);
      if (req[cand]) begin
        gnt_idx   = cand;
        gnt_valid = 1'b1;
      end
    end
    if (gnt_valid) begin
      gnt = N_REQ'(1) << gnt_idx;
    end
  end

endmodule

// File: rtl/beverage_dispense_scheduler.sv
// rtl/beverage_dispense_scheduler.sv - shares one dispense motor and change hopper between vending lanes
module beverage_dispense_scheduler
  import bev_sched_pkg::*;
#(
  parameter int N_REQ     = DEF_N_REQ,
  parameter int CHG_W     = DEF_CHG_W,
  parameter int DISP_CYC  = DEF_DISP_CYC,
  parameter int PULSE_CYC = DEF_PULSE_CYC,
  parameter int GAP_CYC   = DEF_GAP_CYC
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*CHG_W-1:0]   chg_cnt,
  input  logic                     hopper_empty,
  output logic [N_REQ-1:0]         ack,
  output logic                     short,
  output logic [CHG_W-1:0]         short_cnt,
  output logic                     busy,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     motor_en,
  output logic                     collect,
  output logic                     change_out
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int PH_W  = $clog2(max3(DISP_CYC, PULSE_CYC, GAP_CYC)) + 1;

  sched_state_e     state_q, state_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic [CHG_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [N_REQ-1:0] gnt_oh_q, gnt_oh_d;
  logic [IDX_W-1:0] rr_q, rr_d;
  logic             empty_q, empty_d;
  logic             busy_q, busy_d;
  logic             motor_q, motor_d;
  logic             chg_q, chg_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic             short_q, short_d;
  logic [CHG_W-1:0] short_cnt_q, short_cnt_d;

  logic [N_REQ-1:0] arb_gnt;
  logic [IDX_W-1:0] arb_idx;
  logic             arb_valid;
  logic [CHG_W-1:0] sel_cnt;
  logic             go_chg;
  logic             go_done;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req       (req),
    .rr_ptr    (rr_q),
    .gnt       (arb_gnt),
    .gnt_idx   (arb_idx),
    .gnt_valid (arb_valid)
  );

  always_comb begin
    sel_cnt = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (arb_idx == IDX_W'(i)) begin
        sel_cnt = chg_cnt[i*CHG_W +: CHG_W];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    phase_d     = (phase_q != '0) ? phase_q - 1'b1 : phase_q;
    cnt_d       = cnt_q;
    grant_d     = grant_q;
    gnt_oh_d    = gnt_oh_q;
    rr_d        = rr_q;
    empty_d     = empty_q;
    busy_d      = busy_q;
    motor_d     = motor_q;
    chg_d       = chg_q;
    ack_d       = '0;
    short_d     = 1'b0;
    short_cnt_d = '0;
    go_chg      = 1'b0;
    go_done     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (arb_valid) begin
          grant_d  = arb_idx;
          gnt_oh_d = arb_gnt;
          cnt_d    = sel_cnt;
          state_d  = DISP;
          phase_d  = PH_W'(DISP_CYC - 1);
          busy_d   = 1'b1;
          motor_d  = 1'b1;
        end
      end
      DISP: begin
        if (phase_q == '0) begin
          motor_d = 1'b0;
          if (cnt_q != '0) go_chg = 1'b1;
          else             go_done = 1'b1;
        end
      end
      CHG_ON: begin
        // An empty hopper seen on entry abandons the remaining coins.
        if (empty_q) begin
          go_done     = 1'b1;
          short_d     = 1'b1;
          short_cnt_d = cnt_q;
        end else if (phase_q == '0) begin
          chg_d   = 1'b0;
          cnt_d   = cnt_q - 1'b1;
          state_d = CHG_GAP;
          phase_d = PH_W'(GAP_CYC - 1);
        end
      end
      CHG_GAP: begin
        if (phase_q == '0) begin
          if (cnt_q != '0) go_chg = 1'b1;
          else             go_done = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        rr_d    = (grant_q == IDX_W'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // hopper_empty is looked at only on the edge that starts a coin.
    if (go_chg) begin
      state_d = CHG_ON;
      phase_d = PH_W'(PULSE_CYC - 1);
      empty_d = hopper_empty;
      chg_d   = ~hopper_empty;
    end
    if (go_done) begin
      state_d = DONE;
      ack_d   = gnt_oh_q;
      chg_d   = 1'b0;
      motor_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      phase_q     <= '0;
      cnt_q       <= '0;
      grant_q     <= '0;
      gnt_oh_q    <= '0;
      rr_q        <= '0;
      empty_q     <= 1'b0;
      busy_q      <= 1'b0;
      motor_q     <= 1'b0;
      chg_q       <= 1'b0;
      ack_q       <= '0;
      short_q     <= 1'b0;
      short_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      cnt_q       <= cnt_d;
      grant_q     <= grant_d;
      gnt_oh_q    <= gnt_oh_d;
      rr_q        <= rr_d;
      empty_q     <= empty_d;
      busy_q      <= busy_d;
      motor_q     <= motor_d;
      chg_q       <= chg_d;
      ack_q       <= ack_d;
      short_q     <= short_d;
      short_cnt_q <= short_cnt_d;
    end
  end

  assign ack        = ack_q;
  assign short      = short_q;
  assign short_cnt  = short_cnt_q;
  assign busy       = busy_q;
  assign grant_id   = grant_q;
  assign motor_en   = motor_q;
  assign collect    = motor_q;
  assign change_out = chg_q;

endmodule

// File: tb/tb_beverage_dispense_scheduler.sv
// tb/tb_beverage_dispense_scheduler.sv - directed vector bench for the dispense scheduler
module tb_beverage_dispense_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  req = '0;
  logic [11:0] chg_cnt = '0;
  logic        hopper_empty = 1'b0;
  logic [3:0]  ack;
  logic        short;
  logic [2:0]  short_cnt;
  logic        busy;
  logic [1:0]  grant_id;
  logic        motor_en;
  logic        collect;
  logic        change_out;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  beverage_dispense_scheduler dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .chg_cnt      (chg_cnt),
    .hopper_empty (hopper_empty),
    .ack          (ack),
    .short        (short),
    .short_cnt    (short_cnt),
    .busy         (busy),
    .grant_id     (grant_id),
    .motor_en     (motor_en),
    .collect      (collect),
    .change_out   (change_out)
  );

  typedef struct {
    logic [3:0]  req;
    logic [11:0] chg;
    int          empty_after;
    bit          pulse_req;
    int          lane;
    int          motor;
    int          pulses;
    int          ack_t;
    bit          shrt;
    int          shrt_cnt;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [11:0] pk(input int c3, input int c2, input int c1, input int c0);
    return {3'(c3), 3'(c2), 3'(c1), 3'(c0)};
  endfunction

  function automatic vec_t mk(input logic [3:0] r, input logic [11:0] c, input int ea, input bit pr,
                              input int ln, input int np, input int at, input bit sh, input int sc);
    vec_t v;
    v.req = r; v.chg = c; v.empty_after = ea; v.pulse_req = pr; v.lane = ln;
    v.motor = 4; v.pulses = np; v.ack_t = at; v.shrt = sh; v.shrt_cnt = sc;
    return v;
  endfunction

  function automatic int lane_of(input logic [3:0] a);
    int l;
    l = -1;
    for (int i = 0; i < 4; i++) if (a[i]) l = i;
    return l;
  endfunction

  task automatic run_vec(input vec_t v, input string nm);
    int t, motor_n, pulses, coll_err, gid_err, ack_t, got_ack;
    logic prev_chg;
    logic [3:0] ack_v;
    logic sh_v;
    logic [2:0] sc_v;
    t = 0; motor_n = 0; pulses = 0; coll_err = 0; gid_err = 0; ack_t = -1; got_ack = 0;
    prev_chg = 1'b0; ack_v = '0; sh_v = 1'b0; sc_v = '0;
    @(negedge clk);
    req = v.req;
    chg_cnt = v.chg;
    hopper_empty = (v.empty_after == 0);
    while (t < 200 && got_ack == 0) begin
      @(negedge clk);
      t++;
      if (motor_en) motor_n++;
      if (collect !== motor_en) coll_err++;
      if (busy && ack == '0 && int'(grant_id) != v.lane) gid_err++;
      if (change_out && !prev_chg) pulses++;
      if (!change_out && prev_chg && pulses == v.empty_after) hopper_empty = 1'b1;
      prev_chg = change_out;
      if (ack != '0) begin
        got_ack = 1; ack_t = t; ack_v = ack; sh_v = short; sc_v = short_cnt;
        req = '0;
      end
      if (t == 1) begin
        chg_cnt = '1;
        if (v.pulse_req) req = '0;
      end
    end
    check({nm, "_ack_seen"}, got_ack, 1);
    check({nm, "_ack_lane"}, int'(ack_v), 1 << v.lane);
    check({nm, "_ack_time"}, ack_t, v.ack_t);
    check({nm, "_motor_cycles"}, motor_n, v.motor);
    check({nm, "_pulses"}, pulses, v.pulses);
    check({nm, "_short"}, int'(sh_v), int'(v.shrt));
    check({nm, "_short_cnt"}, int'(sc_v), v.shrt_cnt);
    check({nm, "_collect_eq_motor"}, coll_err, 0);
    check({nm, "_grant_id"}, gid_err, 0);
    @(negedge clk);
    check({nm, "_ack_one_cycle"}, int'(ack), 0);
    check({nm, "_busy_dropped"}, int'(busy), 0);
    hopper_empty = 1'b0;
    chg_cnt = '0;
  endtask

  initial begin
    int order[5];
    int n_acks, multi_ack, back_to_back, last_lane, t, seen;

    vecs[0] = mk(4'b0001, pk(0, 0, 0, 0),  99, 1'b0, 0, 0,  5, 1'b0, 0);
    vecs[1] = mk(4'b0100, pk(0, 3, 0, 0),  99, 1'b0, 2, 3, 17, 1'b0, 0);
    vecs[2] = mk(4'b0010, pk(0, 0, 3, 0),   1, 1'b0, 1, 1, 10, 1'b1, 2);
    vecs[3] = mk(4'b1000, pk(2, 0, 0, 0),  99, 1'b1, 3, 2, 13, 1'b0, 0);
    vecs[4] = mk(4'b0001, pk(0, 0, 0, 5),   0, 1'b0, 0, 0,  6, 1'b1, 5);
    vecs[5] = mk(4'b1001, pk(1, 0, 0, 0),  99, 1'b0, 3, 1,  9, 1'b0, 0);
    vecs[6] = mk(4'b0110, pk(0, 0, 0, 0),  99, 1'b0, 1, 0,  5, 1'b0, 0);
    vecs[7] = mk(4'b0100, pk(0, 7, 0, 0),  99, 1'b0, 2, 7, 33, 1'b0, 0);

    #3 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs", int'({ack, short, short_cnt, busy, grant_id, motor_en, collect, change_out}), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Asynchronous reset during a coin pulse.
    @(negedge clk);
    req = 4'b0001; chg_cnt = pk(0, 0, 0, 3); hopper_empty = 1'b0;
    seen = 0;
    for (int c = 0; c < 30 && seen == 0; c++) begin
      @(negedge clk);
      if (change_out) seen = 1;
    end
    check("rst_reached_chg_on", seen, 1);
    req = '0;
    #2 rst_n = 1'b0;
    #1 check("async_reset_outputs", int'({ack, short, busy, motor_en, collect, change_out}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    chg_cnt = '0;

    // All lanes held: first grant proves rr_ptr returned to 0.
    @(negedge clk);
    req = 4'b1111;
    n_acks = 0; multi_ack = 0; back_to_back = 0; last_lane = -1; t = 0;
    while (n_acks < 5 && t < 150) begin
      @(negedge clk);
      t++;
      if (ack != '0) begin
        if ($countones(ack) != 1) multi_ack++;
        if (lane_of(ack) == last_lane) back_to_back++;
        last_lane = lane_of(ack);
        order[n_acks] = last_lane;
        n_acks++;
        @(negedge clk);
        if (ack != '0) multi_ack++;
      end
    end
    req = '0;
    check("rr_ack_count", n_acks, 5);
    for (int i = 0; i < 5; i++) check($sformatf("rr_order%0d", i), (i < n_acks) ? order[i] : -1, i % 4);
    check("rr_onehot_single_cycle", multi_ack, 0);
    check("rr_no_back_to_back", back_to_back, 0);
    repeat (3) @(negedge clk);

    run_vec(mk(4'b0010, pk(0, 0, 0, 0), 99, 1'b0, 1, 0, 5, 1'b0, 0), "post_reset_lane1");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
